debounced_priority_encoder: RTL and testbench

- Inverse of the 3-to-8 one-hot decoder: compresses 8 raw board inputs (switches/buttons) into a 3-bit index of the highest active line.
- Also outputs a valid flag and a one-cycle change strobe.
- Raw inputs are asynchronous to the fabric clock, so each line is synchronized and debounced before encoding.
- Sits between the Basys3 switch/button pins and downstream logic (display drivers, the decoder, control FSMs).

---
 rtl/debounced_priority_encoder.sv | 90 +++++++++
 tb/tb_debounced_priority_encoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/debounced_priority_encoder.sv
// Synchronizes and debounces eight raw board inputs, then reports the index of the
// highest accepted active line with a registered valid flag and a one-cycle change strobe.
module debounced_priority_encoder #(
  parameter int DEB_CYCLES = 100000,
  parameter int CNT_W      = 17
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [7:0] I,
  output logic [2:0] Y,
  output logic       V,
  output logic       CHG
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

  logic [7:0]       sync1_q;
  logic [7:0]       sync2_q;
  logic [7:0]       stable_q;
  logic [7:0]       stable_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [2:0]       y_q;
  logic [2:0]       y_d;
  logic             v_q;
  logic             v_d;
  logic             chg_q;
  logic             chg_d;

  // A line is accepted only after a full unbroken run of mismatching samples;
  // any return to the accepted level throws the partial count away.
  always_comb begin
    stable_d = stable_q;
    for (int b = 0; b < 8; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != stable_q[b]) begin
        if (cnt_q[b] == CntMax) begin
          stable_d[b] = sync2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CNT_W'(1);
        end
      end
    end
  end

  // Ascending scan so the highest set bit wins.
  always_comb begin
    y_d = '0;
    v_d = 1'b0;
    if (EN) begin
      for (int b = 0; b < 8; b++) begin
        if (stable_q[b]) begin
          y_d = 3'(b);
          v_d = 1'b1;
        end
      end
    end
    chg_d = ({v_d, y_d} != {v_q, y_q});
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int b = 0; b < 8; b++) begin
        cnt_q[b] <= '0;
      end
      y_q   <= '0;
      v_q   <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      sync1_q  <= I;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int b = 0; b < 8; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
      y_q   <= y_d;
      v_q   <= v_d;
      chg_q <= chg_d;
    end
  end

  assign Y   = y_q;
  assign V   = v_q;
  assign CHG = chg_q;

endmodule

// File: tb/tb_debounced_priority_encoder.sv
// Directed-vector bench for debounced_priority_encoder with a short debounce window
// so every qualification, glitch, enable and reset scenario fits in a few hundred cycles.
module tb_debounced_priority_encoder;

  localparam int DebCycles = 4;

  logic       clock;
  logic       reset;
  logic       en;
  logic [7:0] inLines;
  logic [2:0] y;
  logic       v;
  logic       chg;

  int checkCount = 0;
  int errorCount = 0;

  debounced_priority_encoder #(
    .DEB_CYCLES(DebCycles),
    .CNT_W(3)
  ) dut (
    .CLK(clock),
    .RST(reset),
    .EN(en),
    .I(inLines),
    .Y(y),
    .V(v),
    .CHG(chg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] expY, input logic expV,
                          input logic expChg);
    checkOutput({tag, ".Y"}, 32'(y), 32'(expY));
    checkOutput({tag, ".V"}, 32'(v), 32'(expV));
    checkOutput({tag, ".CHG"}, 32'(chg), 32'(expChg));
  endtask

  // Inputs always change on the falling edge, so the previous rising edge is edge 0
  // and sampling after n rising edges lands on the next falling edge.
  task automatic applyStimulus(input int edges);
    repeat (edges) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset   = 1'b1;
    en      = 1'b1;
    inLines = 8'h00;
    applyStimulus(2);
    reset = 1'b0;
    checkAll("reset", 3'd0, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      applyStimulus(1);
      checkAll("idle", 3'd0, 1'b0, 1'b0);
    end

    inLines = 8'h01;
    applyStimulus(3);
    inLines = 8'h00;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1);
      checkAll("glitch3", 3'd0, 1'b0, 1'b0);
    end

    inLines = 8'h01;
    applyStimulus(5);
    checkAll("pulse5.e5", 3'd0, 1'b0, 1'b0);
    inLines = 8'h00;
    applyStimulus(1);
    checkAll("pulse5.e6", 3'd0, 1'b0, 1'b0);
    applyStimulus(1);
    checkAll("pulse5.e7", 3'd0, 1'b1, 1'b1);
    applyStimulus(1);
    checkAll("pulse5.e8", 3'd0, 1'b1, 1'b0);
    applyStimulus(3);
    checkAll("pulse5.e11", 3'd0, 1'b1, 1'b0);
    applyStimulus(1);
    checkAll("pulse5.e12", 3'd0, 1'b0, 1'b1);
    applyStimulus(1);
    checkAll("pulse5.e13", 3'd0, 1'b0, 1'b0);

    inLines = 8'h24;
    applyStimulus(6);
    checkAll("h24.e6", 3'd0, 1'b0, 1'b0);
    applyStimulus(1);
    checkAll("h24.e7", 3'd5, 1'b1, 1'b1);
    applyStimulus(1);
    checkAll("h24.e8", 3'd5, 1'b1, 1'b0);

    inLines = 8'h25;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1);
      checkAll("h25.hold", 3'd5, 1'b1, 1'b0);
    end

    inLines = 8'h81;
    applyStimulus(6);
    checkAll("h81.e6", 3'd5, 1'b1, 1'b0);
    applyStimulus(1);
    checkAll("h81.e7", 3'd7, 1'b1, 1'b1);
    applyStimulus(1);
    checkAll("h81.e8", 3'd7, 1'b1, 1'b0);

    inLines = 8'h01;
    applyStimulus(6);
    checkAll("h01.e6", 3'd7, 1'b1, 1'b0);
    applyStimulus(1);
    checkAll("h01.e7", 3'd0, 1'b1, 1'b1);
    applyStimulus(1);
    checkAll("h01.e8", 3'd0, 1'b1, 1'b0);

    inLines = 8'h80;
    applyStimulus(7);
    checkAll("h80.e7", 3'd7, 1'b1, 1'b1);
    applyStimulus(1);
    checkAll("h80.e8", 3'd7, 1'b1, 1'b0);

    en = 1'b0;
    applyStimulus(1);
    checkAll("enOff.e1", 3'd0, 1'b0, 1'b1);
    applyStimulus(1);
    checkAll("enOff.e2", 3'd0, 1'b0, 1'b0);
    en = 1'b1;
    applyStimulus(1);
    checkAll("enOn.e1", 3'd7, 1'b1, 1'b1);
    applyStimulus(1);
    checkAll("enOn.e2", 3'd7, 1'b1, 1'b0);

    inLines = 8'h10;
    applyStimulus(4);
    checkAll("midCount", 3'd7, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkAll("asyncReset", 3'd0, 1'b0, 1'b0);
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(6);
    checkAll("requal.e6", 3'd0, 1'b0, 1'b0);
    applyStimulus(1);
    checkAll("requal.e7", 3'd4, 1'b1, 1'b1);
    applyStimulus(1);
    checkAll("requal.e8", 3'd4, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
